// File: rtl/alu_mult_seq.sv
// Sequential unsigned shift-and-add multiplier that drives an external
// combinational ALU one operation per cycle and returns an N x N -> 2N product.
module alu_mult_seq #(
  parameter int unsigned N = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_op_a,
  input  logic [N-1:0] i_op_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_prod_hi,
  output logic [N-1:0] o_prod_lo,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [2:0]   o_alu_ctrl,
  input  logic [N-1:0] i_alu_q,
  input  logic         i_alu_mayor,
  input  logic         i_alu_paridad
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] ALU_SUMA    = 3'b000;
  localparam logic [2:0] ALU_SHIFT_D = 3'b001;
  localparam logic [2:0] ALU_PASAR_B = 3'b100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [N-1:0]     m;
  logic [N-1:0]     mq;
  logic [N-1:0]     acc;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic [N-1:0]     acc_shift;
  logic [N-1:0]     mq_shift;

  // Shifted {C,ACC,MQ} as written on a SHIFT edge; the ALU supplies ACC>>1.
  always_comb begin
    acc_shift = {c, i_alu_q[N-2:0]};
    mq_shift  = {acc[0], mq[N-1:1]};
  end

  // ALU operation selected purely by the current state.
  always_comb begin
    o_alu_ctrl = ALU_PASAR_B;
    o_alu_a    = '0;
    o_alu_b    = '0;
    case (state)
      TEST: begin
        o_alu_ctrl = ALU_PASAR_B;
        o_alu_b    = mq;
      end
      ADD: begin
        o_alu_ctrl = ALU_SUMA;
        o_alu_a    = acc;
        o_alu_b    = m;
      end
      SHIFT: begin
        o_alu_ctrl = ALU_SHIFT_D;
        o_alu_a    = acc;
      end
      default: begin
        o_alu_ctrl = ALU_PASAR_B;
      end
    endcase
  end

  // Control FSM, datapath registers and registered handshake/product outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      m         <= '0;
      mq        <= '0;
      acc       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_prod_hi <= '0;
      o_prod_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            m      <= i_op_a;
            mq     <= i_op_b;
            acc    <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= TEST;
          end
        end
        TEST: begin
          state <= i_alu_paridad ? ADD : SHIFT;
        end
        ADD: begin
          acc   <= i_alu_q;
          c     <= i_alu_mayor;
          state <= SHIFT;
        end
        SHIFT: begin
          acc <= acc_shift;
          mq  <= mq_shift;
          c   <= 1'b0;
          if (cnt == CNT_W'(N - 1)) begin
            o_prod_hi <= acc_shift;
            o_prod_lo <= mq_shift;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            state     <= DONE;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= TEST;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq with a behavioural model of the ALU.
module tb_alu_mult_seq;

  localparam int unsigned N = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         busy;
  logic         done;
  logic [N-1:0] prod_hi;
  logic [N-1:0] prod_lo;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_ctrl;
  logic [N-1:0] alu_q;
  logic         alu_mayor;
  logic         alu_paridad;

  int  tests_run;
  int  tests_failed;
  bit  saw_add;
  int  illegal_ctrl;

  alu_mult_seq #(.N(N)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_op_a       (op_a),
    .i_op_b       (op_b),
    .o_busy       (busy),
    .o_done       (done),
    .o_prod_hi    (prod_hi),
    .o_prod_lo    (prod_lo),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_ctrl   (alu_ctrl),
    .i_alu_q      (alu_q),
    .i_alu_mayor  (alu_mayor),
    .i_alu_paridad(alu_paridad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: suma / shift_d / pasar_b, parity of the result.
  always_comb begin
    logic [N:0] sum;
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_q     = '0;
    alu_mayor = 1'b0;
    case (alu_ctrl)
      3'b000: begin alu_q = sum[N-1:0]; alu_mayor = sum[N]; end
      3'b001: alu_q = alu_a >> 1;
      3'b100: alu_q = alu_b;
      default: alu_q = '0;
    endcase
    alu_paridad = alu_q[0];
  end

  // Watch the ALU control code for ADD visits and illegal encodings.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_ctrl == 3'b000) saw_add = 1'b1;
      if (alu_ctrl != 3'b000 && alu_ctrl != 3'b001 && alu_ctrl != 3'b100)
        illegal_ctrl = illegal_ctrl + 1;
    end
  end

  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    return (2*N)'(a) * (2*N)'(b);
  endfunction

  function automatic int ref_lat(input logic [N-1:0] b);
    return 2 * N + $countones(b);
  endfunction

  // One multiply from IDLE; optional extra start pulse at edge pulse_at.
  task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b, input int pulse_at,
                          output int lat, output int busy_n, output logic [2*N-1:0] prod,
                          output bit ok);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; saw_add = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; op_a = N'($urandom); op_b = N'($urandom);
    lat = 0; ok = 1'b0;
    busy_n = busy ? 1 : 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == pulse_at) begin
        @(negedge clk);
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      if (busy) busy_n++;
      if (done) begin lat = k; ok = 1'b1; break; end
    end
    prod = {prod_hi, prod_lo};
  endtask

  task automatic check_mult(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input int pulse_at);
    int lat, busy_n;
    logic [2*N-1:0] prod;
    bit ok;
    run_mult(a, b, pulse_at, lat, busy_n, prod, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s_timeout: no done within 200 edges", name);
    end
    tests_run++;
    if (lat !== ref_lat(b)) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, ref_lat(b));
    end
    tests_run++;
    if (prod !== ref_prod(a, b)) begin
      tests_failed++;
      $display("FAIL %s_product: got %h expected %h", name, prod, ref_prod(a, b));
    end
    tests_run++;
    if (busy_n !== ref_lat(b)) begin
      tests_failed++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_n, ref_lat(b));
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_after_done: done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; op_a = '0; op_b = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || {prod_hi, prod_lo} !== 32'h0 || alu_ctrl !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b prod=%h ctrl=%b expected 0 0 0 100",
               busy, done, {prod_hi, prod_lo}, alu_ctrl);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    check_mult("basic_3x5", 16'h0003, 16'h0005, 0);
  endtask

  task automatic test_carry();
    check_mult("carry_ffff", 16'hFFFF, 16'hFFFF, 0);
  endtask

  task automatic test_zero();
    check_mult("zero_b", 16'h1234, 16'h0000, 0);
    tests_run++;
    if (saw_add !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_b_no_add: saw_add=%b expected 0", saw_add);
    end
  endtask

  task automatic test_ignore_start();
    check_mult("ignore_start", 16'h8000, 16'h0002, 7);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || {prod_hi, prod_lo} !== 32'h0001_0000) begin
      tests_failed++;
      $display("FAIL ignore_start_hold: busy=%b done=%b prod=%h expected 0 0 00010000",
               busy, done, {prod_hi, prod_lo});
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; op_a = 16'h00FF; op_b = 16'h0101;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || {prod_hi, prod_lo} !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: busy=%b done=%b prod=%h expected 0 0 0",
               busy, done, {prod_hi, prod_lo});
    end
    @(negedge clk); rst_n = 1'b1;
    check_mult("after_reset_2x3", 16'h0002, 16'h0003, 0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b;
    bit ok;
    int lat;
    a = N'($urandom); b = N'($urandom);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    for (int v = 0; v < 1000; v++) begin
      op_a = N'($urandom); op_b = N'($urandom);
      ok = 1'b0; lat = 0;
      for (int k = 1; k <= 200; k++) begin
        @(posedge clk); #1;
        if (done) begin lat = k; ok = 1'b1; break; end
      end
      tests_run++;
      if (!ok || lat !== ref_lat(b) || {prod_hi, prod_lo} !== ref_prod(a, b)) begin
        tests_failed++;
        $display("FAIL b2b_result[%0d]: a=%h b=%h prod=%h lat=%0d expected %h lat=%0d",
                 v, a, b, {prod_hi, prod_lo}, lat, ref_prod(a, b), ref_lat(b));
        if (!ok) break;
      end
      a = N'($urandom); b = N'($urandom);
      op_a = a; op_b = b;
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_idle[%0d]: done=%b busy=%b expected 0 0", v, done, busy);
      end
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_accept[%0d]: busy=%b expected 1", v, busy);
      end
    end
    start = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; saw_add = 1'b0; illegal_ctrl = 0;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    tests_run++;
    if (illegal_ctrl !== 0) begin
      tests_failed++;
      $display("FAIL alu_ctrl_legal: got %0d illegal codes expected 0", illegal_ctrl);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
